uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter that sits on the SoC data bus as a responder alongside `memory`, decoding its own address window. The CPU writes bytes into a small transmit FIFO. A serializer drains the FIFO onto `tx` at a programmable bit period. Bus transactions use the same strobe/done handshake that `memory` implements.

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_tx_periph_sync_fifo.sv | 59 +++++
 rtl/uart_tx_periph.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, serializer states and the parity helper.
package uart_tx_pkg;

  localparam logic [3:0] TXDATA_OFF  = 4'h0;
  localparam logic [3:0] STATUS_OFF  = 4'h4;
  localparam logic [3:0] DIVISOR_OFF = 4'h8;

  localparam int ST_FULL_BIT   = 0;
  localparam int ST_EMPTY_BIT  = 1;
  localparam int ST_BUSY_BIT   = 2;
  localparam int ST_OVF_BIT    = 3;
  localparam int ST_COUNT_LSB  = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Synchronous FIFO with a synchronous flush; pushes are dropped while full
// and pops are ignored while empty, so the occupancy count never wraps.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: bus decode, register file and serializer.
// Optional even-parity bit is compiled in with UART_TX_PARITY_EN.
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0000_8000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_wstrobe,
  input  logic        mem_rstrobe,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        active,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_s, rd_s;
  logic [3:0]    off_s;
  logic          push_req_s, ovf_clr_s, div_wr_s;
  logic          full_s, empty_s, pop_s, busy_s, bit_end_s, par_on_s;
  logic [CW-1:0] count_s;
  logic [7:0]    head_s;
  logic [31:0]   status_s, rd_val_s;
  logic [15:0]   div_eff_s, reload_s;
  logic [2:0]    idx_nx_s;
  logic          ovf_r;
  logic [15:0]   div_r;
  tx_state_t     state_r;
  logic [15:0]   cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    sh_r;
  logic          tx_r;
  logic          unused_s;

  assign active     = (mem_addr >= BASE) && (mem_addr <= (BASE + 32'd15));
  assign wr_s       = mem_wstrobe & active;
  assign rd_s       = mem_rstrobe & active;
  assign off_s      = {mem_addr[3:2], 2'b00};
  assign push_req_s = wr_s && (off_s == TXDATA_OFF) && mem_wmask[0];
  assign ovf_clr_s  = wr_s && (off_s == STATUS_OFF) && mem_wmask[0] && mem_wdata[ST_OVF_BIT];
  assign div_wr_s   = wr_s && (off_s == DIVISOR_OFF);
  assign unused_s   = ^{mem_addr[1:0], mem_wdata[31:16], mem_wmask[3:2]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .flush (~rst),
    .push  (push_req_s),
    .wdata (mem_wdata[7:0]),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign busy_s = (state_r != TX_IDLE);

  always_comb begin
    status_s               = 32'h0000_0000;
    status_s[ST_FULL_BIT]  = full_s;
    status_s[ST_EMPTY_BIT] = empty_s;
    status_s[ST_BUSY_BIT]  = busy_s;
    status_s[ST_OVF_BIT]   = ovf_r;
    status_s[ST_COUNT_LSB +: 8] = 8'(count_s);
  end

  // Read mux, sampled into mem_rdata before any same-cycle write lands.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (off_s)
      STATUS_OFF:  rd_val_s = status_s;
      DIVISOR_OFF: rd_val_s = {15'h0000, par_on_s, div_r};
      default:     rd_val_s = 32'h0000_0000;
    endcase
  end

  // Bus response: one-cycle done pulse with registered read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_done  <= 1'b0;
      mem_rdata <= 32'h0000_0000;
    end else if (wr_s || rd_s) begin
      mem_done  <= 1'b1;
      mem_rdata <= rd_s ? rd_val_s : 32'h0000_0000;
    end else begin
      mem_done  <= 1'b0;
      mem_rdata <= 32'h0000_0000;
    end
  end

  // Sticky overflow (full is sampled before any same-cycle pop) and divisor lanes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      div_r <= DEFAULT_DIV;
    end else begin
      if (push_req_s && full_s) ovf_r <= 1'b1;
      else if (ovf_clr_s)       ovf_r <= 1'b0;
      if (div_wr_s && mem_wmask[0]) div_r[7:0]  <= mem_wdata[7:0];
      if (div_wr_s && mem_wmask[1]) div_r[15:8] <= mem_wdata[15:8];
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_on_r;
  assign par_on_s = par_on_r;

  // PAR_ON lives in byte lane 2 of DIVISOR.
  always_ff @(posedge clk) begin
    if (!rst)                          par_on_r <= 1'b0;
    else if (div_wr_s && mem_wmask[2]) par_on_r <= mem_wdata[16];
    else                               par_on_r <= par_on_r;
  end
`else
  assign par_on_s = 1'b0;
`endif

  assign div_eff_s = (div_r == 16'd0) ? 16'd1 : div_r;
  assign reload_s  = div_eff_s - 16'd1;
  assign bit_end_s = (cnt_r == 16'd0);
  assign idx_nx_s  = idx_r + 3'd1;

  // A byte is taken from the FIFO on IDLE->START and on STOP->START.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == TX_IDLE) begin
      pop_s = ~empty_s;
    end else if ((state_r == TX_STOP) && bit_end_s) begin
      pop_s = ~empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Serializer; the divisor is re-read at every bit boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= TX_IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      sh_r    <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        TX_IDLE: begin
          tx_r <= 1'b1;
          if (!empty_s) begin
            state_r <= TX_START;
            sh_r    <= head_s;
            cnt_r   <= reload_s;
            tx_r    <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end_s) begin
            state_r <= TX_DATA;
            idx_r   <= 3'd0;
            tx_r    <= sh_r[0];
            cnt_r   <= reload_s;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end_s) begin
            cnt_r <= reload_s;
            if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (par_on_s) begin
                state_r <= TX_PARITY;
                tx_r    <= even_parity(sh_r);
              end else begin
                state_r <= TX_STOP;
                tx_r    <= 1'b1;
              end
`else
              state_r <= TX_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              idx_r <= idx_nx_s;
              tx_r  <= sh_r[idx_nx_s];
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        TX_PARITY: begin
          if (bit_end_s) begin
            state_r <= TX_STOP;
            tx_r    <= 1'b1;
            cnt_r   <= reload_s;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_end_s) begin
            cnt_r <= reload_s;
            if (!empty_s) begin
              state_r <= TX_START;
              sh_r    <= head_s;
              tx_r    <= 1'b0;
            end else begin
              state_r <= TX_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= TX_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_r;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Randomised self-checking bench for uart_tx_periph; a line-level receiver
// model decodes tx independently and register reads are checked against rules.
module tb_uart_tx_periph;

  localparam logic [31:0] BASE = 32'h0000_8000;
  localparam logic [31:0] A_TXDATA = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_DIV    = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wmask = 4'h0;
  logic        mem_wstrobe = 1'b0;
  logic        mem_rstrobe = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        active;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;
  int frame_err = 0;
  int div_m = 104;
  bit par_m = 1'b0;
  logic [7:0] rxq[$];

  uart_tx_periph #(.BASE(BASE), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd104)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .active(active), .tx(tx)
  );

  always #5 clk = ~clk;

  // Receiver model: mid-bit sampling at the bit period latched at the start edge.
  initial begin : rx_model
    int d;
    bit p, ok, abort;
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (rst && tx === 1'b0) begin
        d = div_m; p = par_m; ok = 1'b1; abort = 1'b0; b = 8'h00;
        repeat (d / 2) begin @(posedge clk); #1; if (!rst) abort = 1'b1; end
        if (tx !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (d) begin @(posedge clk); #1; if (!rst) abort = 1'b1; end
          b[k] = tx;
        end
        if (p) begin
          repeat (d) begin @(posedge clk); #1; if (!rst) abort = 1'b1; end
          if (tx !== ^b) ok = 1'b0;
        end
        repeat (d) begin @(posedge clk); #1; if (!rst) abort = 1'b1; end
        if (tx !== 1'b1) ok = 1'b0;
        if (!abort) begin
          rxq.push_back(b);
          if (!ok) frame_err++;
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output bit done_ok);
    @(posedge clk); #1;
    mem_addr = a; mem_wdata = d; mem_wmask = m; mem_wstrobe = 1'b1;
    @(posedge clk); #1;
    mem_wstrobe = 1'b0;
    done_ok = (mem_done === 1'b1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output bit done_ok);
    @(posedge clk); #1;
    mem_addr = a; mem_rstrobe = 1'b1;
    @(posedge clk); #1;
    mem_rstrobe = 1'b0;
    done_ok = (mem_done === 1'b1);
    rd = mem_rdata;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int c = 0;
    while (rxq.size() < n && c < limit) begin @(posedge clk); #1; c++; end
    n_cmp++;
    if (rxq.size() < n) begin
      n_err++;
      $display("FAIL wait_rx: received %0d bytes, need %0d within %0d cycles", rxq.size(), n, limit);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; bit ok;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b1 || mem_done !== 1'b0 || mem_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: tx=%b done=%b rdata=%h need 1 0 0", tx, mem_done, mem_rdata);
    end
    rst = 1'b1;
    bus_read(A_STATUS, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0000_0002) begin
      n_err++; $display("FAIL reset_status: done=%b rdata=%h need 1 00000002", ok, rd);
    end
    bus_read(A_DIV, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'd104) begin
      n_err++; $display("FAIL reset_divisor: done=%b rdata=%h need 1 00000068", ok, rd);
    end
  endtask

  task automatic test_regs_misc();
    logic [31:0] rd; bit ok;
    bus_write(A_TXDATA, 32'h0000_00AA, 4'b1110, ok);
    bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF, ok);
    bus_read(A_STATUS, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0000_0002 || tx !== 1'b1) begin
      n_err++; $display("FAIL masked_push: done=%b status=%h tx=%b need 1 00000002 1", ok, rd, tx);
    end
    bus_read(A_TXDATA, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0) begin n_err++; $display("FAIL txdata_read: %h need 0", rd); end
    bus_read(A_RSVD, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0) begin n_err++; $display("FAIL rsvd_read: %h need 0", rd); end
  endtask

  task automatic test_inactive();
    logic [31:0] probe [4];
    bit exp_act [4];
    int seen = 0;
    probe[0] = BASE + 32'h40; exp_act[0] = 1'b0;
    probe[1] = BASE + 32'hF;  exp_act[1] = 1'b1;
    probe[2] = BASE - 32'h1;  exp_act[2] = 1'b0;
    probe[3] = BASE + 32'h10; exp_act[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_addr = probe[i]; #1;
      n_cmp++;
      if (active !== exp_act[i]) begin
        n_err++; $display("FAIL active_decode: addr=%h active=%b need %b", probe[i], active, exp_act[i]);
      end
    end
    @(posedge clk); #1;
    mem_addr = BASE + 32'h40; mem_rstrobe = 1'b1;
    @(posedge clk); #1;
    mem_rstrobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_done !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL inactive_done: done seen %0d cycles need 0", seen); end
  endtask

  task automatic test_first_byte();
    logic [31:0] rd; bit ok;
    logic [7:0] data = 8'h55;
    logic exp; int bad = 0; int bidx;
    div_m = 4;
    bus_write(A_DIV, 32'd4, 4'b0011, ok);
    bus_write(A_TXDATA, {24'h0, data}, 4'b0001, ok);
    n_cmp++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL first_byte_early: tx=%b need 1", tx); end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bidx = c / 4;
      exp = (bidx == 0) ? 1'b0 : (bidx == 9) ? 1'b1 : data[bidx-1];
      if (tx !== exp) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL frame_0x55: %0d wrong cycles need 0", bad); end
    bus_read(A_STATUS, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0000_0002) begin n_err++; $display("FAIL idle_after_frame: status=%h need 00000002", rd); end
    wait_rx(1, 10);
    n_cmp++;
    if (rxq.size() != 1 || rxq[0] !== data) begin
      n_err++; $display("FAIL rx_0x55: size=%0d byte=%h need 1 55", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
    rxq.delete();
  endtask

  task automatic test_divisor_regs();
    logic [31:0] rd, exp; bit ok;
    logic [7:0] b;
    bus_write(A_DIV, 32'h0000_FF09, 4'b0001, ok);
    bus_write(A_DIV, 32'h0000_0300, 4'b0010, ok);
    bus_read(A_DIV, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0000_0309) begin n_err++; $display("FAIL div_lanes: %h need 00000309", rd); end
    @(posedge clk); #1;
    mem_addr = A_DIV; mem_wdata = 32'h0000_0007; mem_wmask = 4'b0011;
    mem_wstrobe = 1'b1; mem_rstrobe = 1'b1;
    @(posedge clk); #1;
    mem_wstrobe = 1'b0; mem_rstrobe = 1'b0;
    n_cmp++;
    if (mem_done !== 1'b1 || mem_rdata !== 32'h0000_0309) begin
      n_err++; $display("FAIL rw_same_cycle: done=%b rdata=%h need 1 00000309", mem_done, mem_rdata);
    end
    bus_write(A_DIV, 32'h0001_0009, 4'hF, ok);
    bus_read(A_DIV, rd, ok);
`ifdef UART_TX_PARITY_EN
    exp = 32'h0001_0009;
`else
    exp = 32'h0000_0009;
`endif
    n_cmp++;
    if (!ok || rd !== exp) begin n_err++; $display("FAIL div_bit16: %h need %h", rd, exp); end
    div_m = 1;
    bus_write(A_DIV, 32'h0000_0000, 4'b0111, ok);
    bus_read(A_DIV, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0) begin n_err++; $display("FAIL div_zero_read: %h need 0", rd); end
    b = 8'($urandom);
    bus_write(A_TXDATA, {24'h0, b}, 4'b0001, ok);
    wait_rx(1, 40);
    n_cmp++;
    if (rxq.size() != 1 || rxq[0] !== b) begin n_err++; $display("FAIL div_zero_frame: got %0d bytes need 1 of %h", rxq.size(), b); end
    rxq.delete();
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    int d, n; bit ok;
    logic [7:0] b;
    for (int it = 0; it < 5; it++) begin
      d = $urandom_range(1, 6);
      n = $urandom_range(1, 3);
      div_m = d;
      bus_write(A_DIV, d, 4'b0011, ok);
      sent.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        sent.push_back(b);
        bus_write(A_TXDATA, {24'h0, b}, 4'b0001, ok);
      end
      wait_rx(n, n * 10 * d + 50);
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (i >= rxq.size() || rxq[i] !== sent[i]) begin
          n_err++; $display("FAIL random_byte: iter %0d idx %0d got %h need %h", it, i, (i < rxq.size()) ? rxq[i] : 8'hxx, sent[i]);
        end
      end
      rxq.delete();
      repeat (d + 2) @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent [3]; bit ok; int c = 0;
    div_m = 3;
    bus_write(A_DIV, 32'd3, 4'b0011, ok);
    for (int i = 0; i < 3; i++) sent[i] = 8'($urandom);
    bus_write(A_TXDATA, {24'h0, sent[0]}, 4'b0001, ok);
    bus_write(A_TXDATA, {24'h0, sent[1]}, 4'b0001, ok);
    bus_write(A_TXDATA, {24'h0, sent[2]}, 4'b0001, ok);
    repeat (27) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin n_err++; $display("FAIL b2b_start2: tx=%b need 0", tx); end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin n_err++; $display("FAIL b2b_start3: tx=%b need 0", tx); end
    wait_rx(3, 60);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= rxq.size() || rxq[i] !== sent[i]) begin
        n_err++; $display("FAIL b2b_byte: idx %0d got %h need %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, sent[i]);
      end
    end
    rxq.delete();
    while (tx !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
  endtask

  task automatic test_overflow();
    logic [7:0] sent [6]; logic [31:0] rd, exp; bit ok;
    int cnt;
    div_m = 200;
    bus_write(A_DIV, 32'd200, 4'b0011, ok);
    for (int k = 1; k <= 6; k++) begin
      sent[k-1] = 8'($urandom);
      bus_write(A_TXDATA, {24'h0, sent[k-1]}, 4'b0001, ok);
      bus_read(A_STATUS, rd, ok);
      cnt = (k - 1 > 4) ? 4 : k - 1;
      exp = (cnt << 8) | ((k >= 6) ? 32'h8 : 32'h0) | 32'h4 |
            ((cnt == 0) ? 32'h2 : 32'h0) | ((cnt == 4) ? 32'h1 : 32'h0);
      n_cmp++;
      if (!ok || rd !== exp) begin n_err++; $display("FAIL ovf_status: after write %0d status=%h need %h", k, rd, exp); end
    end
    bus_write(A_STATUS, 32'h0000_0008, 4'b0001, ok);
    bus_read(A_STATUS, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0000_0405) begin n_err++; $display("FAIL ovf_clear: status=%h need 00000405", rd); end
    wait_rx(5, 5 * 2000 + 500);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= rxq.size() || rxq[i] !== sent[i]) begin
        n_err++; $display("FAIL ovf_byte: idx %0d got %h need %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, sent[i]);
      end
    end
    rxq.delete();
    repeat (250) @(posedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] bits = {1'b1, 1'b1, 8'h07, 1'b0};
    bit ok; int bad = 0;
    div_m = 2; par_m = 1'b1;
    bus_write(A_DIV, 32'h0001_0002, 4'b0111, ok);
    bus_write(A_TXDATA, 32'h0000_0007, 4'b0001, ok);
    for (int c = 0; c < 23; c++) begin
      @(posedge clk); #1;
      if (tx !== ((c < 22) ? bits[c / 2] : 1'b1)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL parity_frame: %0d wrong cycles need 0", bad); end
    wait_rx(1, 10);
    rxq.delete();
    par_m = 1'b0;
    bus_write(A_DIV, 32'h0000_0004, 4'b0111, ok);
  endtask
`endif

  task automatic test_reset_midframe();
    logic [31:0] rd; bit ok; int c = 0; int highs = 0;
    div_m = 4;
    bus_write(A_DIV, 32'd4, 4'b0011, ok);
    bus_write(A_TXDATA, 32'h0000_00A5, 4'b0001, ok);
    while (tx !== 1'b0 && c < 10) begin @(posedge clk); #1; c++; end
    repeat (17) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin n_err++; $display("FAIL rst_data_bit3: tx=%b need 0", tx); end
    rst = 1'b0; mem_addr = A_STATUS; mem_rstrobe = 1'b1;
    @(posedge clk); #1;
    mem_rstrobe = 1'b0;
    n_cmp++;
    if (tx !== 1'b1 || mem_done !== 1'b0) begin
      n_err++; $display("FAIL rst_midframe: tx=%b done=%b need 1 0", tx, mem_done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus_read(A_STATUS, rd, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0000_0002) begin n_err++; $display("FAIL rst_status: status=%h need 00000002", rd); end
    for (int i = 0; i < 60; i++) begin @(posedge clk); #1; if (tx === 1'b1) highs++; end
    n_cmp++;
    if (highs != 60 || rxq.size() != 0) begin
      n_err++; $display("FAIL rst_no_frame: high cycles %0d bytes %0d need 60 0", highs, rxq.size());
    end
  endtask

  initial begin
    test_reset();
    test_regs_misc();
    test_inactive();
    test_first_byte();
    test_divisor_regs();
    test_random();
    test_back_to_back();
    test_overflow();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    n_cmp++;
    if (frame_err != 0) begin n_err++; $display("FAIL framing: %0d bad frames need 0", frame_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
